// File: rtl/ultrasonic_echo_responder.sv
// Sensor-side HC-SR04 model: accepts a trig pulse and answers with an echo whose width encodes dist_in.
// Optional build macro ULTRASONIC_ECHO_JITTER_EN adds 0..7 cycles of LFSR-driven burst delay jitter.
module ultrasonic_echo_responder #(
    parameter int DIST_W          = 16,
    parameter int TRIG_MIN_CYC    = 1000,
    parameter int BURST_DELAY_CYC = 200,
    parameter int CYC_PER_UNIT    = 100,
    parameter int TIMEOUT_CYC     = 3800000,
    parameter int HOLDOFF_CYC     = 1000
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              trig,
    input  logic [DIST_W-1:0] dist_in,
    input  logic              dist_valid_in,
    output logic              echo,
    output logic              busy,
    output logic              trig_err,
    output logic [15:0]       meas_count
);

    localparam int          PW         = DIST_W + 32;
    localparam logic [31:0] TRIG_MIN   = 32'(TRIG_MIN_CYC);
    localparam logic [31:0] DELAY_BASE = 32'(BURST_DELAY_CYC);
    localparam logic [31:0] TIMEOUT    = 32'(TIMEOUT_CYC);
    localparam logic [31:0] HOLDOFF    = 32'(HOLDOFF_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_DELAY,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] echo_w;
    logic [31:0] delay_tgt;
    logic [2:0]  jitter;
    logic        trig_sync_p0;
    logic        trig_sync_p1;
    logic        trig_sync_p2;
    logic        trig_rise;
    logic        trig_fall;
    logic        accept;

    // Echo width: product clamped to the timeout, zero distance still gives a 1-cycle echo.
    function automatic logic [31:0] calc_width(input logic [DIST_W-1:0] d, input logic v);
        logic [PW-1:0] p;
        p = PW'(d) * PW'(CYC_PER_UNIT);
        if (!v || p > PW'(TIMEOUT_CYC))
            calc_width = TIMEOUT;
        else if (p == '0)
            calc_width = 32'd1;
        else
            calc_width = p[31:0];
    endfunction

    // Stage p0/p1: metastability synchronizer; stage p2: delayed copy for edge detection.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            trig_sync_p0 <= 1'b0;
            trig_sync_p1 <= 1'b0;
            trig_sync_p2 <= 1'b0;
        end else begin
            trig_sync_p0 <= trig;
            trig_sync_p1 <= trig_sync_p0;
            trig_sync_p2 <= trig_sync_p1;
        end
    end

    assign trig_rise = trig_sync_p1 & ~trig_sync_p2;
    assign trig_fall = ~trig_sync_p1 & trig_sync_p2;
    assign accept    = (state == S_TRIG_HI) && trig_fall && (cnt >= TRIG_MIN);

`ifdef ULTRASONIC_ECHO_JITTER_EN
    logic [15:0] lfsr;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign jitter = lfsr[2:0];
`else
    assign jitter = 3'd0;
`endif

    // Transaction data captured at trig acceptance; later dist_in changes cannot disturb it.
    always_ff @(posedge CLK) begin
        if (accept) begin
            echo_w    <= calc_width(dist_in, dist_valid_in);
            delay_tgt <= DELAY_BASE + 32'(jitter);
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            trig_err   <= 1'b0;
            meas_count <= '0;
        end else begin
            trig_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trig_rise) begin
                        cnt   <= 32'd1;
                        state <= S_TRIG_HI;
                    end
                end
                S_TRIG_HI: begin
                    if (accept) begin
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= S_DELAY;
                    end else if (trig_fall) begin
                        trig_err <= 1'b1;
                        cnt      <= '0;
                        state    <= S_IDLE;
                    end else if (cnt < TRIG_MIN) begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DELAY: begin
                    if (cnt >= delay_tgt) begin
                        echo  <= 1'b1;
                        cnt   <= 32'd1;
                        state <= S_ECHO;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_ECHO: begin
                    if (cnt >= echo_w) begin
                        echo       <= 1'b0;
                        meas_count <= meas_count + 16'd1;
                        cnt        <= 32'd1;
                        state      <= S_HOLDOFF;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_HOLDOFF: begin
                    if (cnt >= HOLDOFF) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/ultrasonic_echo_responder.md
Name: ultrasonic_echo_responder

Overview:
Sensor-side model of the ultrasonic ranging interface. It receives the trig pulse from the sensor driver and answers with an echo pulse whose width encodes a programmed distance. Timing follows the HC-SR04 protocol: minimum trig width, burst delay, echo width proportional to distance, timeout on no object. Used for on-chip loopback and self-test of the driver, and as a synthesizable bench model.

Parameters:
DIST_W, 16, width of dist_in
TRIG_MIN_CYC, 1000, minimum accepted trig high width in CLK cycles (10 us at 100 MHz)
BURST_DELAY_CYC, 200, cycles from accepted trig fall to echo rise, excluding the 3-cycle pipeline
CYC_PER_UNIT, 100, echo cycles per distance unit
TIMEOUT_CYC, 3800000, echo width when there is no object, and the maximum echo width
HOLDOFF_CYC, 1000, dead time after echo fall; trig is ignored during it

Ports:
CLK  in  1  system clock
RESET_n  in  1  asynchronous active-low reset
trig  in  1  trigger from driver, asynchronous to CLK
dist_in  in  DIST_W  target distance in units
dist_valid_in  in  1  1 = object present; 0 = no object (timeout echo)
echo  out  1  echo pulse to driver, registered
busy  out  1  high from trig acceptance until holdoff ends
trig_err  out  1  1-cycle pulse when trig is shorter than TRIG_MIN_CYC
meas_count  out  16  number of completed echoes, wraps at 16'hFFFF to 0

Behaviour:
- Reset (async, RESET_n low): echo=0, busy=0, trig_err=0, meas_count=0, state=IDLE, all counters and synchronizer flops =0. Outputs are forced low immediately, without waiting for a clock edge.
- trig passes through a 2-flop synchronizer; a registered copy of the synced value provides edge detection.
- States: IDLE, TRIG_HI, DELAY, ECHO, HOLDOFF.
- IDLE: on a synced trig rising edge, go to TRIG_HI and start the width counter at 1. A trig that is already high on entry to IDLE does not start a measurement; a new rising edge is required.
- TRIG_HI: count while synced trig=1. The counter saturates at TRIG_MIN_CYC. On synced falling edge:
  - count >= TRIG_MIN_CYC: latch dist_in and dist_valid_in, busy=1, go to DELAY.
  - otherwise: trig_err=1 for one cycle, go to IDLE, busy stays 0.
- DELAY: count BURST_DELAY_CYC cycles, then echo=1 and go to ECHO. Total latency from the first CLK edge sampling trig low at the pin to echo high is BURST_DELAY_CYC+3 cycles.
- Echo width W is computed at latch time:
  - DIST_W+32-bit product P = dist*CYC_PER_UNIT.
  - W = TIMEOUT_CYC if valid=0 or P > TIMEOUT_CYC.
  - W = 1 if P = 0.
  - otherwise W = P.
- ECHO: echo stays high for exactly W cycles, then echo=0, meas_count increments, go to HOLDOFF.
- HOLDOFF: wait HOLDOFF_CYC cycles, then busy=0 and go to IDLE.
- Trig edges during DELAY, ECHO or HOLDOFF are ignored, with no trig_err. Changes to dist_in or dist_valid_in after latching have no effect on the current echo.
- Reset asserted mid-operation aborts the echo at once (echo=0) and discards the count. After release the block waits for a fresh rising edge.

Optional Feature:
ULTRASONIC_ECHO_JITTER_EN:
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every CLK. At DELAY entry, its low 3 bits (0..7) are added to BURST_DELAY_CYC to model acoustic jitter.
- Undefined: no LFSR is built and the delay is exactly BURST_DELAY_CYC.
- Echo width is unaffected in both cases.

Test Plan:
- trig high 1100 cycles, dist_in=25, valid=1 -> echo rises 203 cycles after trig fall, stays high exactly 2500 cycles; meas_count=1; busy falls 1000 cycles after echo fall.
- trig high 500 cycles -> one 1-cycle trig_err pulse, echo never rises, busy=0, meas_count unchanged.
- valid=0, trig 1100 cycles -> echo high 3800000 cycles; dist_in=50000, valid=1 -> clamped to 3800000; dist_in=0 -> echo high 1 cycle.
- Second 1100-cycle trig pulse during ECHO and another during HOLDOFF; trig held high across the return to IDLE -> width unchanged, no trig_err, no new measurement until trig goes low then high again.
- RESET_n low 500 cycles into ECHO -> echo=0 and busy=0 with no clock edge required, meas_count=0; next valid trig yields a normal echo.
- Jitter macro defined, 16 consecutive measurements -> each rise delay is in 203..210 cycles and not all delays are equal; undefined -> all exactly 203.
